// File: rtl/l1_ahb_mtx_pkg.sv
// ============================================================================
// Module   : l1_ahb_mtx_pkg
// Brief    : Shared AHB encodings, arbiter state and burst helpers for the
//            N-input matrix output stage.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package l1_ahb_mtx_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  typedef enum logic [1:0] {
    ARB_FREE       = 2'd0,
    ARB_HOLD_BURST = 2'd1,
    ARB_HOLD_LOCK  = 2'd2
  } arb_state_e;

  // Beats still to come after the NONSEQ of a fixed-length burst.
  function automatic logic [3:0] burst_beats(input logic [2:0] hburst);
    case (hburst)
      HBURST_WRAP4,  HBURST_INCR4:  burst_beats = 4'd3;
      HBURST_WRAP8,  HBURST_INCR8:  burst_beats = 4'd7;
      HBURST_WRAP16, HBURST_INCR16: burst_beats = 4'd15;
      default:                      burst_beats = 4'd0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/l1_ahb_mtx_arb_n.sv
// ============================================================================
// Module   : l1_ahb_mtx_arb_n
// Brief    : Burst- and lock-aware arbiter (fixed priority or round-robin).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module l1_ahb_mtx_arb_n
  import l1_ahb_mtx_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int PORT_W    = 2,
  parameter int ARB_MODE  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 hready,
  input  logic                 hsel,
  input  logic [1:0]           htrans,
  input  logic [2:0]           hburst,
  input  logic                 mastlock,
  output logic [PORT_W-1:0]    addr_port,
  output logic                 no_port
);

  arb_state_e        state_q, state_d;
  logic [PORT_W-1:0] addr_port_q, addr_port_d;
  logic [PORT_W-1:0] rr_ptr_q, rr_ptr_d;
  logic              no_port_q, no_port_d;
  logic              hsel_lock_q, hsel_lock_d;
  logic [3:0]        beat_cnt_q, beat_cnt_d;

  logic              hlock_arb;
  logic              in_burst;
  logic [1:0]        trans_eff;
  logic [PORT_W-1:0] win;
  logic              win_vld;
  logic [PORT_W:0]   base;
  logic [PORT_W:0]   cand;

  assign hlock_arb = mastlock & (hsel_lock_q | hsel);
  assign trans_eff = hsel ? htrans : HTRANS_IDLE;
  assign in_burst  = (state_q != ARB_FREE) && (beat_cnt_q != 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_FREE;
      addr_port_q <= '0;
      rr_ptr_q    <= '0;
      no_port_q   <= 1'b1;
      hsel_lock_q <= 1'b0;
      beat_cnt_q  <= 4'd0;
    end else if (hready) begin
      state_q     <= state_d;
      addr_port_q <= addr_port_d;
      rr_ptr_q    <= rr_ptr_d;
      no_port_q   <= no_port_d;
      hsel_lock_q <= hsel_lock_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

  always_comb begin
    hsel_lock_d = hsel_lock_q;
    if (hsel & htrans[1] & mastlock) begin
      hsel_lock_d = 1'b1;
    end else if (!mastlock) begin
      hsel_lock_d = 1'b0;
    end

    beat_cnt_d = beat_cnt_q;
    if (in_burst) begin
      case (trans_eff)
        HTRANS_SEQ:  beat_cnt_d = beat_cnt_q - 4'd1;
        HTRANS_BUSY: beat_cnt_d = beat_cnt_q;
        default:     beat_cnt_d = 4'd0;  // IDLE or NONSEQ ends the burst early
      endcase
    end else if (trans_eff == HTRANS_NONSEQ) begin
      beat_cnt_d = burst_beats(hburst);
    end

    if (hlock_arb) begin
      state_d = ARB_HOLD_LOCK;
    end else if (beat_cnt_d != 4'd0) begin
      state_d = ARB_HOLD_BURST;
    end else begin
      state_d = ARB_FREE;
    end
  end

  // Cyclic search starting at the priority base; fixed priority starts at 0.
  always_comb begin
    win     = addr_port_q;
    win_vld = 1'b0;
    base    = (ARB_MODE == 0) ? '0 : {1'b0, rr_ptr_q};
    cand    = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = base + (PORT_W+1)'(k);
      if (cand >= (PORT_W+1)'(NUM_PORTS)) begin
        cand = cand - (PORT_W+1)'(NUM_PORTS);
      end
      if (!win_vld && req[cand[PORT_W-1:0]]) begin
        win     = cand[PORT_W-1:0];
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    addr_port_d = addr_port_q;
    no_port_d   = no_port_q;
    rr_ptr_d    = rr_ptr_q;
    if (state_d == ARB_FREE) begin
      if (win_vld) begin
        addr_port_d = win;
        no_port_d   = 1'b0;
        rr_ptr_d    = (win == PORT_W'(NUM_PORTS - 1)) ? '0 : win + PORT_W'(1);
      end else begin
        no_port_d   = 1'b1;
      end
    end
  end

  assign addr_port = addr_port_q;
  assign no_port   = no_port_q;

endmodule

`default_nettype wire

// File: rtl/l1_ahb_mtx_out_stg_n.sv
// ============================================================================
// Module   : l1_ahb_mtx_out_stg_n
// Brief    : N-input AHB-Lite matrix output stage; address mux, data mux one
//            data phase behind, and slave ready tracking.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module l1_ahb_mtx_out_stg_n
  import l1_ahb_mtx_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int PORT_W    = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int ARB_MODE  = 1
) (
  input  logic                        HCLK,
  input  logic                        HRESETn,
  input  logic [NUM_PORTS-1:0]        sel_op,
  input  logic [NUM_PORTS*ADDR_W-1:0] addr_op,
  input  logic [NUM_PORTS*2-1:0]      trans_op,
  input  logic [NUM_PORTS-1:0]        write_op,
  input  logic [NUM_PORTS*3-1:0]      size_op,
  input  logic [NUM_PORTS*3-1:0]      burst_op,
  input  logic [NUM_PORTS*4-1:0]      prot_op,
  input  logic [NUM_PORTS*4-1:0]      master_op,
  input  logic [NUM_PORTS-1:0]        mastlock_op,
  input  logic [NUM_PORTS*DATA_W-1:0] wdata_op,
  input  logic [NUM_PORTS-1:0]        held_tran_op,
  input  logic                        HREADYOUTM,
  output logic [NUM_PORTS-1:0]        active_op,
  output logic                        HSELM,
  output logic [ADDR_W-1:0]           HADDRM,
  output logic [1:0]                  HTRANSM,
  output logic                        HWRITEM,
  output logic [2:0]                  HSIZEM,
  output logic [2:0]                  HBURSTM,
  output logic [3:0]                  HPROTM,
  output logic [3:0]                  HMASTERM,
  output logic                        HMASTLOCKM,
  output logic                        HREADYMUXM,
  output logic [DATA_W-1:0]           HWDATAM
);

  logic [ADDR_W-1:0] addr_a   [NUM_PORTS];
  logic [1:0]        trans_a  [NUM_PORTS];
  logic [2:0]        size_a   [NUM_PORTS];
  logic [2:0]        burst_a  [NUM_PORTS];
  logic [3:0]        prot_a   [NUM_PORTS];
  logic [3:0]        master_a [NUM_PORTS];
  logic [DATA_W-1:0] wdata_a  [NUM_PORTS];

  logic [NUM_PORTS-1:0] req;
  logic [PORT_W-1:0]    addr_port;
  logic                 no_port;
  logic [PORT_W-1:0]    data_port_q, data_port_d;
  logic                 slave_sel_q, slave_sel_d;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
      assign addr_a[gi]   = addr_op[gi*ADDR_W +: ADDR_W];
      assign trans_a[gi]  = trans_op[gi*2 +: 2];
      assign size_a[gi]   = size_op[gi*3 +: 3];
      assign burst_a[gi]  = burst_op[gi*3 +: 3];
      assign prot_a[gi]   = prot_op[gi*4 +: 4];
      assign master_a[gi] = master_op[gi*4 +: 4];
      assign wdata_a[gi]  = wdata_op[gi*DATA_W +: DATA_W];
    end
  endgenerate

  assign req = held_tran_op & sel_op;

  l1_ahb_mtx_arb_n #(
    .NUM_PORTS (NUM_PORTS),
    .PORT_W    (PORT_W),
    .ARB_MODE  (ARB_MODE)
  ) u_arb (
    .clk       (HCLK),
    .rst_n     (HRESETn),
    .req       (req),
    .hready    (HREADYMUXM),
    .hsel      (HSELM),
    .htrans    (HTRANSM),
    .hburst    (HBURSTM),
    .mastlock  (HMASTLOCKM),
    .addr_port (addr_port),
    .no_port   (no_port)
  );

  always_comb begin
    active_op  = '0;
    HSELM      = 1'b0;
    HADDRM     = '0;
    HTRANSM    = HTRANS_IDLE;
    HWRITEM    = 1'b0;
    HSIZEM     = 3'd0;
    HBURSTM    = HBURST_SINGLE;
    HPROTM     = 4'd0;
    HMASTERM   = 4'd0;
    HMASTLOCKM = 1'b0;
    if (!no_port) begin
      active_op[addr_port] = 1'b1;
      HSELM      = sel_op[addr_port];
      HADDRM     = addr_a[addr_port];
      HTRANSM    = trans_a[addr_port];
      HWRITEM    = write_op[addr_port];
      HSIZEM     = size_a[addr_port];
      HBURSTM    = burst_a[addr_port];
      HPROTM     = prot_a[addr_port];
      HMASTERM   = master_a[addr_port];
      HMASTLOCKM = mastlock_op[addr_port];
    end
  end

  assign HREADYMUXM  = slave_sel_q ? HREADYOUTM : 1'b1;
  assign data_port_d = HREADYMUXM ? addr_port : data_port_q;
  assign slave_sel_d = HREADYMUXM ? HSELM : slave_sel_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      data_port_q <= '0;
      slave_sel_q <= 1'b0;
    end else begin
      data_port_q <= data_port_d;
      slave_sel_q <= slave_sel_d;
    end
  end

  assign HWDATAM = wdata_a[data_port_q];

endmodule

`default_nettype wire

// File: tb/tb_l1_ahb_mtx_out_stg_n.sv
// ============================================================================
// Module   : tb_l1_ahb_mtx_out_stg_n
// Brief    : Directed self-checking bench for the N-input output stage.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_l1_ahb_mtx_out_stg_n;
  import l1_ahb_mtx_pkg::*;

  localparam int NP = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  logic HREADYOUTM = 1'b1;
  always #5 HCLK = ~HCLK;

  logic [NP-1:0] sel_v, write_v, lock_v, held_v;
  logic [1:0]    trans_a [NP];
  logic [2:0]    burst_a [NP];
  logic [AW-1:0] addr_a  [NP];
  logic [DW-1:0] wdata_a [NP];

  logic [NP*AW-1:0] addr_op;
  logic [NP*2-1:0]  trans_op;
  logic [NP*3-1:0]  size_op, burst_op;
  logic [NP*4-1:0]  prot_op, master_op;
  logic [NP*DW-1:0] wdata_op;

  always_comb begin
    addr_op = '0; trans_op = '0; size_op = '0; burst_op = '0;
    prot_op = '0; master_op = '0; wdata_op = '0;
    for (int i = 0; i < NP; i++) begin
      addr_op[i*AW +: AW]  = addr_a[i];
      trans_op[i*2 +: 2]   = trans_a[i];
      size_op[i*3 +: 3]    = 3'b010;
      burst_op[i*3 +: 3]   = burst_a[i];
      prot_op[i*4 +: 4]    = 4'b0011;
      master_op[i*4 +: 4]  = 4'(i);
      wdata_op[i*DW +: DW] = wdata_a[i];
    end
  end

  logic [NP-1:0] active_op;
  logic          HSELM, HWRITEM, HMASTLOCKM, HREADYMUXM;
  logic [AW-1:0] HADDRM;
  logic [1:0]    HTRANSM;
  logic [2:0]    HSIZEM, HBURSTM;
  logic [3:0]    HPROTM, HMASTERM;
  logic [DW-1:0] HWDATAM;

  l1_ahb_mtx_out_stg_n #(
    .NUM_PORTS(NP), .PORT_W(2), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(1)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .sel_op(sel_v), .addr_op(addr_op),
    .trans_op(trans_op), .write_op(write_v), .size_op(size_op),
    .burst_op(burst_op), .prot_op(prot_op), .master_op(master_op),
    .mastlock_op(lock_v), .wdata_op(wdata_op), .held_tran_op(held_v),
    .HREADYOUTM(HREADYOUTM), .active_op(active_op), .HSELM(HSELM),
    .HADDRM(HADDRM), .HTRANSM(HTRANSM), .HWRITEM(HWRITEM), .HSIZEM(HSIZEM),
    .HBURSTM(HBURSTM), .HPROTM(HPROTM), .HMASTERM(HMASTERM),
    .HMASTLOCKM(HMASTLOCKM), .HREADYMUXM(HREADYMUXM), .HWDATAM(HWDATAM)
  );

  // Three-port fixed-priority instance sharing the lower port inputs.
  logic [2:0]    fp_active;
  logic          fp_hsel, fp_hwrite, fp_hlock, fp_hready;
  logic [AW-1:0] fp_haddr;
  logic [1:0]    fp_htrans;
  logic [2:0]    fp_hsize, fp_hburst;
  logic [3:0]    fp_hprot, fp_hmaster;
  logic [DW-1:0] fp_hwdata;

  l1_ahb_mtx_out_stg_n #(
    .NUM_PORTS(3), .PORT_W(2), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(0)
  ) dut_fp (
    .HCLK(HCLK), .HRESETn(HRESETn), .sel_op(sel_v[2:0]),
    .addr_op(addr_op[3*AW-1:0]), .trans_op(trans_op[5:0]),
    .write_op(write_v[2:0]), .size_op(size_op[8:0]), .burst_op(burst_op[8:0]),
    .prot_op(prot_op[11:0]), .master_op(master_op[11:0]),
    .mastlock_op(lock_v[2:0]), .wdata_op(wdata_op[3*DW-1:0]),
    .held_tran_op(held_v[2:0]), .HREADYOUTM(HREADYOUTM),
    .active_op(fp_active), .HSELM(fp_hsel), .HADDRM(fp_haddr),
    .HTRANSM(fp_htrans), .HWRITEM(fp_hwrite), .HSIZEM(fp_hsize),
    .HBURSTM(fp_hburst), .HPROTM(fp_hprot), .HMASTERM(fp_hmaster),
    .HMASTLOCKM(fp_hlock), .HREADYMUXM(fp_hready), .HWDATAM(fp_hwdata)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drv(input int p, input logic s, input logic h, input logic [1:0] t,
                     input logic [2:0] b, input logic [31:0] a, input logic l);
    sel_v[p] = s; held_v[p] = h; trans_a[p] = t; burst_a[p] = b;
    addr_a[p] = a; lock_v[p] = l; write_v[p] = 1'b1;
  endtask

  task automatic idle_all();
    for (int p = 0; p < NP; p++) drv(p, 1'b0, 1'b0, HTRANS_IDLE, HBURST_SINGLE, 32'h0, 1'b0);
  endtask

  task automatic nextc();
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_all();
    for (int i = 0; i < NP; i++) wdata_a[i] = 32'hA0 + 32'(i);
    #12;
    chk("rst_hsel",   32'(HSELM), 32'h0);
    chk("rst_hready", 32'(HREADYMUXM), 32'h1);
    chk("rst_active", 32'(active_op), 32'h0);
    chk("rst_htrans", 32'(HTRANSM), 32'h0);
    chk("rst_hwdata", HWDATAM, 32'hA0);
    chk("rst_fp_act", 32'(fp_active), 32'h0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    nextc(); #1;
    chk("idle_active", 32'(active_op), 32'h0);
    chk("idle_hready", 32'(HREADYMUXM), 32'h1);

    // Round-robin versus fixed priority, three SINGLE requesters
    drv(0, 1, 1, HTRANS_NONSEQ, HBURST_SINGLE, 32'h100, 0);
    drv(1, 1, 1, HTRANS_NONSEQ, HBURST_SINGLE, 32'h200, 0);
    drv(2, 1, 1, HTRANS_NONSEQ, HBURST_SINGLE, 32'h300, 0);
    #1;
    chk("rr_pre", 32'(active_op), 32'h0);
    nextc(); #1;
    chk("rr_g0", 32'(active_op), 32'h1);
    chk("rr_addr0", HADDRM, 32'h100);
    chk("fp_g0", 32'(fp_active), 32'h1);
    nextc(); #1;
    chk("rr_g1", 32'(active_op), 32'h2);
    chk("rr_wd0", HWDATAM, 32'hA0);
    nextc(); #1;
    chk("rr_g2", 32'(active_op), 32'h4);
    chk("rr_wd1", HWDATAM, 32'hA1);
    chk("fp_g0b", 32'(fp_active), 32'h1);
    nextc(); idle_all(); #1;
    chk("rr_g3", 32'(active_op), 32'h1);
    chk("rr_wd2", HWDATAM, 32'hA2);
    chk("fp_g0c", 32'(fp_active), 32'h1);
    nextc(); #1;
    chk("rr_none", 32'(active_op), 32'h0);

    // INCR4 from port 1 holds off port 0
    drv(0, 1, 1, HTRANS_NONSEQ, HBURST_SINGLE, 32'h0, 0);
    drv(1, 1, 1, HTRANS_NONSEQ, HBURST_INCR4, 32'h1000, 0);
    nextc(); #1;
    chk("b_g1", 32'(active_op), 32'h2);
    chk("b_addr0", HADDRM, 32'h1000);
    chk("b_burst", 32'(HBURSTM), 32'(HBURST_INCR4));
    chk("b_wd_late", HWDATAM, 32'hA0);
    nextc(); drv(1, 1, 1, HTRANS_SEQ, HBURST_INCR4, 32'h1004, 0); wdata_a[1] = 32'hB1; #1;
    chk("b_hold1", 32'(active_op), 32'h2);
    chk("b_wd1", HWDATAM, 32'hB1);
    nextc(); drv(1, 1, 1, HTRANS_SEQ, HBURST_INCR4, 32'h1008, 0); wdata_a[1] = 32'hB2; #1;
    chk("b_hold2", 32'(active_op), 32'h2);
    nextc(); drv(1, 1, 1, HTRANS_SEQ, HBURST_INCR4, 32'h100C, 0); wdata_a[1] = 32'hB3; #1;
    chk("b_hold3", 32'(active_op), 32'h2);
    chk("b_addr3", HADDRM, 32'h100C);
    nextc(); drv(1, 0, 0, HTRANS_IDLE, HBURST_SINGLE, 32'h0, 0); wdata_a[1] = 32'hB4; #1;
    chk("b_rel", 32'(active_op), 32'h1);
    chk("b_wd4", HWDATAM, 32'hB4);
    idle_all();
    nextc(); #1;
    chk("b_none", 32'(active_op), 32'h0);

    // Locked sequence on port 2 with HSEL dropped while locked
    drv(2, 1, 1, HTRANS_NONSEQ, HBURST_SINGLE, 32'h2000, 1);
    drv(0, 1, 1, HTRANS_NONSEQ, HBURST_SINGLE, 32'h0, 0);
    nextc(); #1;
    chk("c_g2", 32'(active_op), 32'h4);
    chk("c_mlock", 32'(HMASTLOCKM), 32'h1);
    nextc(); drv(2, 0, 0, HTRANS_IDLE, HBURST_SINGLE, 32'h2000, 1); #1;
    chk("c_lock1", 32'(active_op), 32'h4);
    chk("c_hsel0", 32'(HSELM), 32'h0);
    nextc(); #1;
    chk("c_lock2", 32'(active_op), 32'h4);
    nextc(); drv(2, 0, 0, HTRANS_IDLE, HBURST_SINGLE, 32'h2000, 0); #1;
    chk("c_lock3", 32'(active_op), 32'h4);
    nextc(); #1;
    chk("c_g0", 32'(active_op), 32'h1);
    chk("c_hsel1", 32'(HSELM), 32'h1);
    idle_all();
    nextc(); #1;
    chk("c_none", 32'(active_op), 32'h0);

    // WRAP8 on port 1 with a 3-cycle slave stall, port 3 waiting
    drv(1, 1, 1, HTRANS_NONSEQ, HBURST_WRAP8, 32'h3000, 0);
    drv(3, 1, 1, HTRANS_NONSEQ, HBURST_SINGLE, 32'h5000, 0);
    nextc(); #1;
    chk("d_g1", 32'(active_op), 32'h2);
    for (int b = 1; b < 4; b++) begin
      nextc(); drv(1, 1, 1, HTRANS_SEQ, HBURST_WRAP8, 32'h3000 + 32'(4*b), 0);
      wdata_a[1] = 32'hC0 + 32'(b - 1); #1;
      chk("d_hold_pre", 32'(active_op), 32'h2);
    end
    nextc(); drv(1, 1, 1, HTRANS_SEQ, HBURST_WRAP8, 32'h3010, 0);
    wdata_a[1] = 32'hC3; HREADYOUTM = 1'b0; #1;
    chk("d_stall_rdy", 32'(HREADYMUXM), 32'h0);
    chk("d_stall_wd", HWDATAM, 32'hC3);
    for (int s = 0; s < 2; s++) begin
      nextc(); #1;
      chk("d_frz_rdy", 32'(HREADYMUXM), 32'h0);
      chk("d_frz_addr", HADDRM, 32'h3010);
      chk("d_frz_act", 32'(active_op), 32'h2);
      chk("d_frz_wd", HWDATAM, 32'hC3);
    end
    nextc(); HREADYOUTM = 1'b1; #1;
    chk("d_unstall", 32'(HREADYMUXM), 32'h1);
    chk("d_unst_act", 32'(active_op), 32'h2);
    for (int b = 5; b < 8; b++) begin
      nextc(); drv(1, 1, 1, HTRANS_SEQ, HBURST_WRAP8, 32'h3000 + 32'(4*b), 0);
      wdata_a[1] = 32'hC0 + 32'(b - 1); #1;
      chk("d_hold_post", 32'(active_op), 32'h2);
    end
    nextc(); drv(1, 0, 0, HTRANS_IDLE, HBURST_SINGLE, 32'h0, 0); wdata_a[1] = 32'hC7; #1;
    chk("d_rel", 32'(active_op), 32'h8);
    chk("d_addr3", HADDRM, 32'h5000);
    chk("d_wd8", HWDATAM, 32'hC7);
    idle_all();
    nextc(); #1;
    chk("d_none", 32'(active_op), 32'h0);

    // INCR8 on port 1 aborted with IDLE after two beats, port 3 waiting
    drv(1, 1, 1, HTRANS_NONSEQ, HBURST_INCR8, 32'h4000, 0);
    drv(3, 1, 1, HTRANS_NONSEQ, HBURST_SINGLE, 32'h5000, 0);
    nextc(); #1;
    chk("e_g1", 32'(active_op), 32'h2);
    nextc(); drv(1, 1, 1, HTRANS_SEQ, HBURST_INCR8, 32'h4004, 0); #1;
    chk("e_hold", 32'(active_op), 32'h2);
    nextc(); drv(1, 1, 0, HTRANS_IDLE, HBURST_INCR8, 32'h4008, 0); #1;
    chk("e_idle_act", 32'(active_op), 32'h2);
    chk("e_idle_tr", 32'(HTRANSM), 32'(HTRANS_IDLE));
    nextc(); #1;
    chk("e_abort", 32'(active_op), 32'h8);
    chk("e_hsel3", 32'(HSELM), 32'h1);

    // Asynchronous reset mid-cycle
    #2; HRESETn = 1'b0; #1;
    chk("r_active", 32'(active_op), 32'h0);
    chk("r_hsel", 32'(HSELM), 32'h0);
    chk("r_hready", 32'(HREADYMUXM), 32'h1);
    chk("r_hwdata", HWDATAM, 32'hA0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
